// File: rtl/date_counter.sv
// Calendar stage (day/month/year) with leap handling; define DATE_GREGORIAN_CENTURY_EN for the full %100/%400 century rule.
// Latency 1: fields and carry_out register on the edge that samples carry_in or detects an up/down edge.
// No backpressure: carry_in arriving while adjusting or with en_1 low is dropped, never queued.
module date_counter (
  input  logic        clk_1Hz,
  input  logic        rst_n,
  input  logic        en_1,
  input  logic        carry_in,
  input  logic [2:0]  select_item,
  input  logic        up,
  input  logic        down,
  output logic [4:0]  day_bin,
  output logic [3:0]  month_bin,
  output logic [13:0] year_bin,
  output logic        carry_out
);

  localparam logic [2:0]  SELECT_DAY   = 3'b011;
  localparam logic [2:0]  SELECT_MONTH = 3'b100;
  localparam logic [2:0]  SELECT_YEAR  = 3'b101;
  localparam logic [13:0] YEAR_RESET   = 14'd2000;
  localparam logic [13:0] YEAR_MAX     = 14'd9999;

  function automatic logic is_leap(input logic [13:0] y);
`ifdef DATE_GREGORIAN_CENTURY_EN
    return ((y[1:0] == 2'b00) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
`else
    return (y[1:0] == 2'b00);
`endif
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  function automatic logic [4:0] clamp_day(input logic [4:0] d, input logic [4:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  logic        up_q;
  logic        down_q;
  logic        up_p;
  logic        down_p;
  logic        step_up;
  logic        step_dn;
  logic        adjust_mode;
  logic [4:0]  cur_dim;
  logic [4:0]  day_n;
  logic [3:0]  month_n;
  logic [13:0] year_n;
  logic        carry_n;

  assign up_p        = up & ~up_q;
  assign down_p      = down & ~down_q;
  // Simultaneous up and down edges cancel out.
  assign step_up     = up_p & ~down_p;
  assign step_dn     = down_p & ~up_p;
  assign adjust_mode = (select_item == SELECT_DAY) || (select_item == SELECT_MONTH) ||
                       (select_item == SELECT_YEAR);
  assign cur_dim     = days_in_month(month_bin, year_bin);

  always_comb begin
    day_n   = day_bin;
    month_n = month_bin;
    year_n  = year_bin;
    carry_n = 1'b0;
    if (adjust_mode) begin
      case (select_item)
        SELECT_DAY: begin
          if (step_up)
            day_n = (day_bin >= cur_dim) ? 5'd1 : day_bin + 5'd1;
          else if (step_dn)
            day_n = (day_bin <= 5'd1) ? cur_dim : day_bin - 5'd1;
        end
        SELECT_MONTH: begin
          if (step_up)
            month_n = (month_bin >= 4'd12) ? 4'd1 : month_bin + 4'd1;
          else if (step_dn)
            month_n = (month_bin <= 4'd1) ? 4'd12 : month_bin - 4'd1;
          day_n = clamp_day(day_bin, days_in_month(month_n, year_bin));
        end
        SELECT_YEAR: begin
          if (step_up)
            year_n = (year_bin >= YEAR_MAX) ? 14'd0 : year_bin + 14'd1;
          else if (step_dn)
            year_n = (year_bin == 14'd0) ? YEAR_MAX : year_bin - 14'd1;
          day_n = clamp_day(day_bin, days_in_month(month_bin, year_n));
        end
        default: ;
      endcase
    end else if (en_1 && carry_in) begin
      if (day_bin < cur_dim) begin
        day_n = day_bin + 5'd1;
      end else if (month_bin < 4'd12) begin
        day_n   = 5'd1;
        month_n = month_bin + 4'd1;
      end else begin
        day_n   = 5'd1;
        month_n = 4'd1;
        if (year_bin >= YEAR_MAX) begin
          year_n  = 14'd0;
          carry_n = 1'b1;
        end else begin
          year_n = year_bin + 14'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      day_bin   <= 5'd1;
      month_bin <= 4'd1;
      year_bin  <= YEAR_RESET;
      carry_out <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      day_bin   <= day_n;
      month_bin <= month_n;
      year_bin  <= year_n;
      carry_out <= carry_n;
      up_q      <= up;
      down_q    <= down;
    end
  end

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: rollover, leap years, wrap, adjust clamp, dropped inputs and reset.
`timescale 1ns/1ps
module tb_date_counter;

  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_DAY   = 3'b011;
  localparam logic [2:0] SEL_MONTH = 3'b100;
  localparam logic [2:0] SEL_YEAR  = 3'b101;

  logic        clk_1Hz = 1'b0;
  logic        rst_n;
  logic        en_1;
  logic        carry_in;
  logic [2:0]  select_item;
  logic        up;
  logic        down;
  logic [4:0]  day_bin;
  logic [3:0]  month_bin;
  logic [13:0] year_bin;
  logic        carry_out;

  int errors = 0;
  int checks = 0;

  date_counter dut (
    .clk_1Hz     (clk_1Hz),
    .rst_n       (rst_n),
    .en_1        (en_1),
    .carry_in    (carry_in),
    .select_item (select_item),
    .up          (up),
    .down        (down),
    .day_bin     (day_bin),
    .month_bin   (month_bin),
    .year_bin    (year_bin),
    .carry_out   (carry_out)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic tick();
    @(posedge clk_1Hz);
    @(negedge clk_1Hz);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_date(input string tag, input int d, input int m, input int y, input logic co);
    chk({tag, "_day"},   32'(day_bin),   d);
    chk({tag, "_month"}, 32'(month_bin), m);
    chk({tag, "_year"},  32'(year_bin),  y);
    chk({tag, "_cout"},  32'(carry_out), 32'(co));
  endtask

  task automatic adj(input logic [2:0] sel, input logic dir_up);
    select_item = sel;
    up          = dir_up;
    down        = ~dir_up;
    tick();
    up   = 1'b0;
    down = 1'b0;
    tick();
    select_item = SEL_NONE;
  endtask

  task automatic carry_tick();
    carry_in = 1'b1;
    tick();
    carry_in = 1'b0;
  endtask

  // Steers the DUT to a date via its adjust controls; each walk is bounded.
  task automatic set_date(input int d, input int m, input int y);
    int n;
    n = 0;
    while (int'(year_bin) != y && n < 12000) begin
      adj(SEL_YEAR, y > int'(year_bin));
      n++;
    end
    chk("nav_year", 32'(year_bin), y);
    n = 0;
    while (int'(month_bin) != m && n < 20) begin
      adj(SEL_MONTH, m > int'(month_bin));
      n++;
    end
    chk("nav_month", 32'(month_bin), m);
    n = 0;
    while (int'(day_bin) != d && n < 40) begin
      adj(SEL_DAY, d > int'(day_bin));
      n++;
    end
    chk("nav_day", 32'(day_bin), d);
  endtask

  initial begin
    rst_n       = 1'b0;
    en_1        = 1'b1;
    carry_in    = 1'b0;
    select_item = SEL_NONE;
    up          = 1'b0;
    down        = 1'b0;
    tick();
    chk_date("reset", 1, 1, 2000, 1'b0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk_date("hold", 1, 1, 2000, 1'b0);

    set_date(28, 2, 2023);
    carry_tick();
    chk_date("feb_nonleap", 1, 3, 2023, 1'b0);

    set_date(28, 2, 2024);
    carry_tick();
    chk_date("feb_leap_29", 29, 2, 2024, 1'b0);
    carry_tick();
    chk_date("feb_leap_mar", 1, 3, 2024, 1'b0);

    set_date(30, 4, 2024);
    carry_tick();
    chk_date("apr_30", 1, 5, 2024, 1'b0);

    set_date(29, 2, 2024);
    adj(SEL_YEAR, 1'b1);
    chk_date("year_clamp", 28, 2, 2025, 1'b0);

    set_date(31, 1, 2023);
    select_item = SEL_MONTH;
    up = 1'b1;
    tick(); tick(); tick();
    chk_date("month_held_clamp", 28, 2, 2023, 1'b0);
    up = 1'b0;
    tick();
    select_item = SEL_NONE;

    set_date(1, 3, 2023);
    adj(SEL_DAY, 1'b0);
    chk_date("day_down_wrap", 31, 3, 2023, 1'b0);

    select_item = SEL_DAY;
    carry_tick();
    chk_date("drop_adjust", 31, 3, 2023, 1'b0);
    select_item = SEL_NONE;
    en_1 = 1'b0;
    carry_tick();
    chk_date("drop_en", 31, 3, 2023, 1'b0);
    en_1 = 1'b1;
    select_item = SEL_DAY;
    up = 1'b1;
    down = 1'b1;
    tick();
    chk_date("up_down_both", 31, 3, 2023, 1'b0);
    up = 1'b0;
    down = 1'b0;
    tick();
    select_item = SEL_NONE;
    up = 1'b1;
    tick();
    up = 1'b0;
    tick();
    chk_date("up_no_select", 31, 3, 2023, 1'b0);

    set_date(1, 1, 2023);
    adj(SEL_MONTH, 1'b0);
    chk_date("month_down_wrap", 1, 12, 2023, 1'b0);
    adj(SEL_MONTH, 1'b1);
    chk_date("month_up_wrap", 1, 1, 2023, 1'b0);

    set_date(30, 4, 2023);
    adj(SEL_DAY, 1'b1);
    chk_date("day_up_wrap", 1, 4, 2023, 1'b0);

    set_date(28, 2, 2100);
    carry_tick();
`ifdef DATE_GREGORIAN_CENTURY_EN
    chk_date("y2100", 1, 3, 2100, 1'b0);
`else
    chk_date("y2100", 29, 2, 2100, 1'b0);
`endif

    set_date(1, 1, 0);
    select_item = SEL_YEAR;
    down = 1'b1;
    tick();
    chk_date("year_down_wrap", 1, 1, 9999, 1'b0);
    down = 1'b0;
    tick();
    up = 1'b1;
    tick();
    chk_date("year_up_wrap", 1, 1, 0, 1'b0);
    up = 1'b0;
    tick();
    down = 1'b1;
    tick();
    down = 1'b0;
    tick();
    select_item = SEL_NONE;

    set_date(31, 12, 9999);
    carry_tick();
    chk_date("millennium_wrap", 1, 1, 0, 1'b1);
    tick();
    chk_date("carry_one_cycle", 1, 1, 0, 1'b0);

    carry_tick();
    chk_date("year0_day2", 2, 1, 0, 1'b0);
    carry_in = 1'b1;
    rst_n    = 1'b0;
    tick();
    chk_date("reset_override", 1, 1, 2000, 1'b0);
    carry_in = 1'b0;
    rst_n    = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
